led_frame_ram_pingpong: RTL
===========================

Name: led_frame_ram_pingpong

Overview:
Parametrised, double-buffered LED frame store built from BANKS narrow RAM banks, all in a single clock domain.
- The host/packet writer fills the back page while the scan/PWM reader streams the front page.
- A swap handshake exchanges the pages only on a frame boundary, so a displayed frame is never torn.
- Read path is fully registered: bank select is pipelined with the RAM data, and out-of-range banks are trapped.

Parameters:
DATA_W, 8, width of one pixel/colour word
BANKS, 9, number of RAM banks (1..2**BSEL_W)
BSEL_W, 4, width of bank-select field in address
LANE_W, 2, width of low address field kept inside a bank
ROW_W, 7, width of high address field kept inside a bank
ADDR_W, ROW_W+BSEL_W+LANE_W (13), logical address width; address = {row, bank, lane}

Ports:
clock  in  1  sole clock, all logic on rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  write strobe, one word per cycle
wr_addr  in  ADDR_W  logical write address (back page)
wr_data  in  DATA_W  write data
rd_en  in  1  read request, one per cycle allowed
rd_addr  in  ADDR_W  logical read address (front page)
q  out  DATA_W  read data
q_valid  out  1  q valid, exactly 2 cycles after rd_en
swap_req  in  1  pulse: back page complete
frame_sync  in  1  pulse: reader at frame boundary
swap_pending  out  1  swap requested, not yet executed
swap_done  out  1  1-cycle pulse when pages exchanged
front_page  out  1  page currently read (0/1)
swap_overrun  out  1  1-cycle pulse: swap_req while already pending
addr_err  out  1  sticky: access with bank field >= BANKS; cleared only by reset

Behaviour:
- Bank storage: each bank holds 2 pages x 2**(ROW_W+LANE_W) words.
  - Bank-internal address = {page, row, lane}.
  - Bank b is written when wr_en is high and wr_addr bank field == b.
- Page selection:
  - Writes target page ~front_page, sampled in the wr_en cycle.
  - Reads target front_page, sampled in the rd_en cycle. In-flight reads finish from the page captured at issue, even across a swap.
- Read pipeline:
  - Cycle 0: rd_en with address.
  - Cycle 1: all banks present registered data; bank index, in-range flag and valid are registered alongside.
  - Cycle 2: registered output mux drives q and asserts q_valid.
  - Back-to-back rd_en gives one q per cycle. q holds its last value when q_valid=0.
- Out-of-range bank (field >= BANKS):
  - Write: dropped, and addr_err is set.
  - Read: q=0 with q_valid=1, and addr_err is set.
- No read/write collision is possible: read and write pages always differ.
- Swap FSM has two states, IDLE and PENDING:
  - IDLE: swap_req & !frame_sync goes to PENDING. swap_req & frame_sync swaps immediately and stays in IDLE.
  - PENDING: frame_sync swaps and returns to IDLE. swap_req without frame_sync pulses swap_overrun and stays in PENDING.
  - A swap toggles front_page on the next edge and pulses swap_done in that same cycle.
  - A write in the swap cycle still goes to the pre-toggle back page.
  - swap_pending = (state==PENDING).
- Reset:
  - front_page=0, state IDLE, q=0, q_valid=0.
  - swap_done, swap_overrun, swap_pending and addr_err are all 0.
  - Pipeline valids are flushed, so a read in flight at reset produces no q_valid.
  - RAM contents are not cleared.

Optional Feature:
Macro LED_FRAME_RAM_PARITY_EN.
- Defined:
  - Each bank word is widened by 1 even-parity bit computed on wr_data.
  - The read path re-checks parity at cycle 2.
  - New output rd_parity_err (1 bit) pulses together with q_valid on a mismatch. It is forced 0 for out-of-range reads and is reset to 0.
- Undefined: no parity storage and no rd_parity_err port.
- All other behaviour is identical in both builds.

Decomposition:
- Package led_frame_ram_pkg holds:
  - address field widths and derived ADDR_W;
  - function splitting address into row/bank/lane;
  - swap FSM state enum (IDLE, PENDING);
  - localparam for read latency (2).
- Sub-module led_bank_dpram: one clock, 1W1R, synchronous registered read, width DATA_W(+1 with parity), depth 2**(1+ROW_W+LANE_W).
  - Instantiated BANKS times via generate.

Test Plan:
- Write 0xA5 to addr 0x0047 (row1, bank1, lane3) after reset; swap_req then frame_sync; read 0x0047 -> q=0xA5, q_valid exactly 2 cycles after rd_en.
- Before swap, read 0x0047 -> q=0x00-initialised front data (not 0xA5). Stream 16 back-to-back reads -> 16 consecutive q_valid cycles, order preserved.
- swap_req at cycle 10, frame_sync at cycle 20 -> swap_pending high cycles 11-20, swap_done at 20, front_page 0->1 at 21. A second swap_req at cycle 15 -> swap_overrun pulse at 15.
- swap_req and frame_sync together -> immediate swap_done, swap_pending never high. A read issued the cycle before returns old-page data.
- Write/read with bank field 9 or 15 (e.g. addr 0x0024, 0x003C) -> no bank written, read q=0 with q_valid=1, addr_err sticky until reset.
- Assert reset with 2 reads in flight -> no q_valid afterwards, front_page=0. With LED_FRAME_RAM_PARITY_EN, a forced bit flip in a bank -> rd_parity_err pulse together with q_valid.

Source files
------------

// File: rtl/led_frame_ram_pkg.sv
// Shared address layout, swap FSM states and read latency for the LED frame store.
package led_frame_ram_pkg;

    localparam int ROW_W      = 7;
    localparam int BSEL_W     = 4;
    localparam int LANE_W     = 2;
    localparam int ADDR_W     = ROW_W + BSEL_W + LANE_W;
    localparam int BANK_AW    = 1 + ROW_W + LANE_W;
    localparam int RD_LATENCY = 2;

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_e;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [BSEL_W-1:0] bank;
        logic [LANE_W-1:0] lane;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        split_addr = addr_fields_t'(addr);
    endfunction

endpackage

// File: rtl/led_bank_dpram.sv
// One frame-store bank: single clock, one write port, one registered read port.
module led_bank_dpram #(
    parameter int WORD_W = 8,
    parameter int AW     = 10
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [2**AW];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/led_frame_ram_pingpong.sv
// Double-buffered banked LED frame store with frame-synchronous page swap.
// Optional even-parity protection per word when LED_FRAME_RAM_PARITY_EN is defined.
module led_frame_ram_pingpong
    import led_frame_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BANKS  = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    input  logic              swap_req,
    input  logic              frame_sync,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              front_page,
    output logic              swap_overrun,
    output logic              addr_err
`ifdef LED_FRAME_RAM_PARITY_EN
    ,
    output logic              rd_parity_err
`endif
);

`ifdef LED_FRAME_RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    addr_fields_t      wr_f;
    addr_fields_t      rd_f;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] bank_rdata [BANKS];
    logic [WORD_W-1:0] rd_word;

    swap_state_e       state_q, state_d;
    logic              front_page_q, front_page_d;
    logic              swap_fire, overrun;

    logic              rd_valid1_q;
    logic              rd_inrange1_q;
    logic [BSEL_W-1:0] rd_bank1_q;
    logic [DATA_W-1:0] q_q;
    logic              q_valid_q;
    logic              addr_err_q;

    assign wr_f        = split_addr(wr_addr);
    assign rd_f        = split_addr(rd_addr);
    assign wr_in_range = {1'b0, wr_f.bank} < (BSEL_W+1)'(BANKS);
    assign rd_in_range = {1'b0, rd_f.bank} < (BSEL_W+1)'(BANKS);

`ifdef LED_FRAME_RAM_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    // Writes always land in the back page, reads in the front page, so the two never collide.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        led_bank_dpram #(
            .WORD_W (WORD_W),
            .AW     (BANK_AW)
        ) u_bank (
            .clock   (clock),
            .we_i    (wr_en && (wr_f.bank == BSEL_W'(b))),
            .waddr_i ({~front_page_q, wr_f.row, wr_f.lane}),
            .wdata_i (wr_word),
            .re_i    (rd_en && (rd_f.bank == BSEL_W'(b))),
            .raddr_i ({front_page_q, rd_f.row, rd_f.lane}),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (rd_bank1_q == BSEL_W'(b)) begin
                rd_word = bank_rdata[b];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
        overrun   = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req && frame_sync) begin
                    swap_fire = 1'b1;
                end else if (swap_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_sync) begin
                    swap_fire = 1'b1;
                    state_d   = IDLE;
                end else if (swap_req) begin
                    overrun = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            swap_fire = 1'b0;
            overrun   = 1'b0;
        end
        front_page_d = front_page_q ^ swap_fire;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            front_page_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_page_q <= front_page_d;
        end
    end

    // Bank index and range flag travel with the RAM read so the output mux sees them together.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid1_q   <= 1'b0;
            rd_inrange1_q <= 1'b0;
            rd_bank1_q    <= '0;
            q_q           <= '0;
            q_valid_q     <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            rd_valid1_q   <= rd_en;
            rd_inrange1_q <= rd_in_range;
            rd_bank1_q    <= rd_f.bank;
            q_valid_q     <= rd_valid1_q;
            if (rd_valid1_q) begin
                q_q <= rd_inrange1_q ? rd_word[DATA_W-1:0] : '0;
            end
            addr_err_q <= addr_err_q | (wr_en & ~wr_in_range) | (rd_en & ~rd_in_range);
        end
    end

`ifdef LED_FRAME_RAM_PARITY_EN
    logic rd_parity_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_parity_err_q <= 1'b0;
        end else begin
            rd_parity_err_q <= rd_valid1_q & rd_inrange1_q & (^rd_word);
        end
    end

    assign rd_parity_err = rd_parity_err_q;
`endif

    assign q            = q_q;
    assign q_valid      = q_valid_q;
    assign swap_pending = (state_q == PENDING);
    assign swap_done    = swap_fire;
    assign swap_overrun = overrun;
    assign front_page   = front_page_q;
    assign addr_err     = addr_err_q;

endmodule
